ws2812_frame_driver: RTL and testbench
======================================

Name: ws2812_frame_driver

Overview:
- Reader/consumer side of the per-LED colour interface.
- Sweeps `current_led` over 0..MAX_POS-1 and samples the three intensity bytes returned combinationally by the screen compositor.
- Serialises each LED as 24 bits GRB, MSB first, on a single WS2812-style NRZ data line, then holds a low latch period.
- Sits between the screen compositor and the top-level LED strip pin; one instance drives the whole strip.

Parameters:
- MAX_POS, 109, number of LEDs on the strip; `current_led` counts 0..MAX_POS-1.
- T0H_CYCLES, 20, clock cycles `dout` stays high for a '0' bit (0.4 us @ 50 MHz).
- T1H_CYCLES, 40, clock cycles `dout` stays high for a '1' bit (0.8 us @ 50 MHz).
- BIT_CYCLES, 63, total clock cycles per bit (1.26 us @ 50 MHz).
- RESET_CYCLES, 3000, low cycles after the last LED (60 us latch).
- Legal range: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES, RESET_CYCLES >= 1, MAX_POS >= 2.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one frame; sampled only in IDLE.
- current_led  output  $clog2(MAX_POS)  LED index presented to the compositor.
- led_green_intensity  input  8  G byte for `current_led`, valid combinationally.
- led_red_intensity  input  8  R byte for `current_led`.
- led_blue_intensity  input  8  B byte for `current_led`.
- dout  output  1  serial strip data, registered.
- busy  output  1  high from LOAD entry through the end of LATCH.
- frame_done  output  1  one-cycle pulse on return to IDLE after a frame.

Behaviour:
- Reset (async, immediate, mid-frame included): state=IDLE, current_led=0, dout=0, busy=0, frame_done=0, shift register=0, all counters=0. No frame resumes after reset release; a new `start` is required.
- States: IDLE, LOAD, SEND, LATCH.
- IDLE:
  - dout=0, busy=0.
  - start=1 at an edge -> LOAD on that edge; current_led=0; busy=1 from that edge.
  - start while busy is ignored; no queueing.
- LOAD (exactly 1 cycle, dout=0):
  - At its closing edge, latch {G,R,B} into a 24-bit shift register (G[7] first).
  - Reset bit index=0 and phase counter=0; go to SEND.
  - current_led is stable for the whole LOAD cycle, so compositor inputs are settled.
- SEND:
  - Phase counter c runs 0..BIT_CYCLES-1 per bit.
  - dout=1 on cycles with c < TH and 0 otherwise, where TH = T1H_CYCLES if the current MSB is 1, else T0H_CYCLES. dout is a registered output.
  - At c=BIT_CYCLES-1: shift left by 1, increment bit index.
  - After bit 23, if current_led < MAX_POS-1: increment current_led, go to LOAD. The inter-LED gap is 1 extra low cycle.
  - After bit 23, if current_led == MAX_POS-1: go to LATCH; current_led holds.
- LATCH:
  - dout=0 for exactly RESET_CYCLES cycles.
  - Then IDLE, current_led=0, busy=0, frame_done=1 for the first IDLE cycle.
  - start sampled in that same cycle is accepted (back-to-back frames).
- Frame length, from the first LOAD cycle to the frame_done cycle: MAX_POS*(1+24*BIT_CYCLES) + RESET_CYCLES cycles.
- Widths: current_led never exceeds MAX_POS-1; there is no wrap-around to 0 except via LATCH->IDLE.
- Bit index width 5 bits. Phase counter width $clog2(BIT_CYCLES). Latch counter width $clog2(RESET_CYCLES+1).
- Intensity inputs are sampled only at the LOAD edge. Changes during SEND do not affect the bits in flight.

Test Plan (bench override: MAX_POS=3, T0H=2, T1H=4, BIT=6, RESET=10 unless stated):
- Reset held, then released with start=0 -> dout=0, busy=0, frame_done=0, current_led=0 for 20 cycles.
- start pulse; compositor returns G=0xA5, R=0x00, B=0xFF for every LED:
  - per LED, dout high-widths are 4,2,4,2,2,4,2,4 | eight ×2 | eight ×4.
  - frame_done asserted exactly 3*(1+144)+10 = 445 cycles after LOAD entry.
- LED-dependent colour (G = current_led): decoded G bytes are 0x00, 0x01, 0x02 in order, and current_led steps 0->1->2 only at LOAD boundaries.
- start held high for the whole frame -> exactly one frame; a second frame begins in the frame_done cycle (back-to-back), with busy low for that single cycle only.
- rst_n asserted mid-bit of LED 1 while dout=1 -> dout=0 asynchronously; busy=0, current_led=0; no activity until the next start.
- Inputs changed mid-SEND (G 0xFF->0x00 at bit 3) -> the transmitted G byte stays 0xFF.

Source files
------------

// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver
//   Walks current_led over the whole strip and reads the compositor's GRB bytes
//   for each LED. Each LED goes out as 24 NRZ bits, MSB first. A low latch
//   period follows the last LED.
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   start               request one frame (sampled in IDLE only)
//   current_led         LED index presented to the compositor
//   led_*_intensity     colour bytes for current_led (combinational from compositor)
//   dout                registered serial strip data
//   busy                high from LOAD entry through the end of LATCH
//   frame_done          one-cycle pulse on the first IDLE cycle after a frame
//
// state | meaning
// IDLE  | line low, waiting for start
// LOAD  | one cycle, current_led settled; GRB latched at the closing edge
// SEND  | shifting 24 bits, each BIT_CYCLES long
// LATCH | line held low RESET_CYCLES cycles before returning to IDLE
module ws2812_frame_driver #(
  parameter int MAX_POS      = 109,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int BIT_CYCLES   = 63,
  parameter int RESET_CYCLES = 3000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [$clog2(MAX_POS)-1:0] current_led,
  input  logic [7:0]                 led_green_intensity,
  input  logic [7:0]                 led_red_intensity,
  input  logic [7:0]                 led_blue_intensity,
  output logic                       dout,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int LED_W = $clog2(MAX_POS);
  localparam int PH_W  = $clog2(BIT_CYCLES);
  localparam int LAT_W = $clog2(RESET_CYCLES + 1);

  localparam logic [LED_W-1:0] LED_LAST = LED_W'(MAX_POS - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_CYCLES - 1);
  localparam logic [PH_W-1:0]  T0H_C    = PH_W'(T0H_CYCLES);
  localparam logic [PH_W-1:0]  T1H_C    = PH_W'(T1H_CYCLES);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t           state_q, state_nxt;
  logic [LED_W-1:0] led_q, led_nxt;
  logic [23:0]      shift_q, shift_nxt;
  logic [4:0]       bit_q, bit_nxt;
  logic [PH_W-1:0]  ph_q, ph_nxt;
  logic [LAT_W-1:0] lat_q, lat_nxt;
  logic             dout_q, dout_nxt;
  logic             done_q, done_nxt;

  // Line level for a given bit value at phase ph.
  function automatic logic high_at(input logic msb, input logic [PH_W-1:0] ph);
    return ph < (msb ? T1H_C : T0H_C);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      led_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      lat_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      led_q   <= led_nxt;
      shift_q <= shift_nxt;
      bit_q   <= bit_nxt;
      ph_q    <= ph_nxt;
      lat_q   <= lat_nxt;
      dout_q  <= dout_nxt;
      done_q  <= done_nxt;
    end
  end

  // dout_nxt is the line level for the cycle that the next state/phase
  // describes, so the registered dout lines up with the phase counter.
  always_comb begin
    state_nxt = state_q;
    led_nxt   = led_q;
    shift_nxt = shift_q;
    bit_nxt   = bit_q;
    ph_nxt    = ph_q;
    lat_nxt   = lat_q;
    dout_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          led_nxt   = '0;
        end
      end
      LOAD: begin
        shift_nxt = {led_green_intensity, led_red_intensity, led_blue_intensity};
        bit_nxt   = '0;
        ph_nxt    = '0;
        state_nxt = SEND;
        dout_nxt  = high_at(led_green_intensity[7], '0);
      end
      SEND: begin
        if (ph_q == PH_LAST) begin
          if (bit_q == 5'd23) begin
            if (led_q == LED_LAST) begin
              state_nxt = LATCH;
              lat_nxt   = LAT_LOAD;
            end else begin
              led_nxt   = led_q + LED_W'(1);
              state_nxt = LOAD;
            end
          end else begin
            shift_nxt = {shift_q[22:0], 1'b0};
            bit_nxt   = bit_q + 5'd1;
            ph_nxt    = '0;
            dout_nxt  = high_at(shift_q[22], '0);
          end
        end else begin
          ph_nxt   = ph_q + PH_W'(1);
          dout_nxt = high_at(shift_q[23], ph_q + PH_W'(1));
        end
      end
      LATCH: begin
        if (lat_q == '0) begin
          state_nxt = IDLE;
          led_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          lat_nxt = lat_q - LAT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign current_led = led_q;
  assign dout        = dout_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
module tb_ws2812_frame_driver;
  localparam int MAX_POS   = 3;
  localparam int T0H       = 2;
  localparam int T1H       = 4;
  localparam int BITC      = 6;
  localparam int RSTC      = 10;
  localparam int FRAME_LEN = MAX_POS * (1 + 24 * BITC) + RSTC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] current_led;
  logic [7:0] g, r, b;
  logic       dout, busy, frame_done;

  logic [7:0] g_arr[4];
  logic [7:0] r_arr[4];
  logic [7:0] b_arr[4];

  // Compositor model: combinational lookup by LED index.
  assign g = g_arr[current_led];
  assign r = r_arr[current_led];
  assign b = b_arr[current_led];

  ws2812_frame_driver #(
    .MAX_POS(MAX_POS), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .BIT_CYCLES(BITC), .RESET_CYCLES(RSTC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .current_led(current_led),
    .led_green_intensity(g), .led_red_intensity(r), .led_blue_intensity(b),
    .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int frames_done = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: decodes the NRZ line into GRB words and checks against the queue.
  initial begin
    int hi;
    int nb;
    int led_idx;
    logic [23:0] word;
    logic prev_busy;
    int cyc;
    int load_cyc;
    hi = 0; nb = 0; led_idx = 0; word = '0; prev_busy = 1'b0; cyc = 0; load_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hi = 0; nb = 0; led_idx = 0; word = '0; prev_busy = 1'b0;
        continue;
      end
      if (busy && !prev_busy) load_cyc = cyc;
      prev_busy = busy;
      if (frame_done) begin
        frames_done++;
        check("frame_len", cyc - load_cyc, FRAME_LEN);
        check("busy_low_in_done", busy, 0);
        check("bits_left_at_done", nb, 0);
        led_idx = 0;
      end
      if (dout) begin
        if (hi == 0) check("led_index_at_bit", current_led, led_idx);
        hi++;
      end else if (hi > 0) begin
        check("pulse_width_legal", (hi == T0H || hi == T1H), 1);
        word = {word[22:0], (hi == T1H)};
        nb++;
        hi = 0;
        if (nb == 24) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_word: got %06h expected none", word);
          end else begin
            check("grb_word", word, exp_q.pop_front());
          end
          nb = 0;
          led_idx++;
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!frame_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!frame_done) begin
      n_cmp++; n_err++;
      $display("FAIL frame_done_timeout: got none expected pulse within %0d", budget);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_checks(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, {busy, dout, frame_done, current_led}, 0);
    end
  endtask

  task automatic fill_fixed();
    for (int i = 0; i < 4; i++) begin
      g_arr[i] = 8'hA5; r_arr[i] = 8'h00; b_arr[i] = 8'hFF;
    end
  endtask

  task automatic fill_random(input bit g_is_index);
    for (int i = 0; i < 4; i++) begin
      g_arr[i] = g_is_index ? 8'(i) : 8'($urandom);
      r_arr[i] = 8'($urandom);
      b_arr[i] = 8'($urandom);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < MAX_POS; i++) exp_q.push_back({g_arr[i], r_arr[i], b_arr[i]});
  endtask

  initial begin
    int k;
    fill_fixed();
    repeat (4) @(negedge clk);
    check("in_reset", {busy, dout, frame_done, current_led}, 0);
    rst_n = 1'b1;
    idle_checks("idle_after_reset", 20);

    // Fixed colour: high widths 4,2,4,2,2,4,2,4 | 2 x8 | 4 x8.
    fill_fixed();
    push_frame();
    pulse_start();
    wait_done(1000);

    // G follows LED index; R/B random.
    for (int f = 0; f < 2; f++) begin
      fill_random(1'b1);
      push_frame();
      pulse_start();
      wait_done(1000);
    end

    // Fully random frames.
    for (int f = 0; f < 2; f++) begin
      fill_random(1'b0);
      push_frame();
      pulse_start();
      wait_done(1000);
    end

    // start held: back-to-back frames, busy low only in the done cycle.
    fill_random(1'b0);
    push_frame();
    push_frame();
    @(negedge clk);
    start = 1'b1;
    wait_done(1000);
    check("b2b_busy_done_cycle", busy, 0);
    @(negedge clk);
    check("b2b_busy_next", busy, 1);
    check("b2b_led_next", current_led, 0);
    start = 1'b0;
    @(negedge clk);
    wait_done(1000);
    k = frames_done;
    idle_checks("idle_after_b2b", 20);
    check("no_extra_frame", frames_done, k);

    // Input change mid-SEND of LED 0 does not affect bits in flight.
    fill_random(1'b0);
    for (int i = 0; i < 4; i++) g_arr[i] = 8'hFF;
    exp_q.push_back({8'hFF, r_arr[0], b_arr[0]});
    exp_q.push_back({8'h00, r_arr[1], b_arr[1]});
    exp_q.push_back({8'h00, r_arr[2], b_arr[2]});
    pulse_start();
    repeat (20) @(negedge clk);
    check("midsend_led0", current_led, 0);
    for (int i = 0; i < 4; i++) g_arr[i] = 8'h00;
    wait_done(1000);

    // Async reset mid-bit of LED 1 while dout is high.
    fill_fixed();
    push_frame();
    pulse_start();
    k = 0;
    while (!(current_led == 2'd1 && dout) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("reached_led1_high", {current_led, dout}, {2'd1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", {busy, dout, frame_done, current_led}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_checks("idle_after_mid_reset", 20);

    // Recovery frame after reset.
    fill_random(1'b1);
    push_frame();
    pulse_start();
    wait_done(1000);
    repeat (3) @(negedge clk);

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
